// File: rtl/axil_cmd_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : axil_cmd_master
// Brief   : Single-outstanding command-to-AXI4-Lite master with a timeout abort.
// Revision: 1.0
// ============================================================================
module axil_cmd_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WRITE = 2'd1;
    localparam logic [1:0] c_READ  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    // Counter only needs to reach TIMEOUT-1: the abort fires on the edge that would make it TIMEOUT.
    localparam int               c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic             c_TO_EN    = (TIMEOUT != 0);

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_rdata;
    logic [1:0]            r_rsp_resp;
    logic                  r_rsp_timeout;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic                  r_awvalid;
    logic [31:0]           r_wdata;
    logic                  r_wvalid;
    logic                  r_bready;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  w_timeout;

    assign w_timeout = c_TO_EN && (r_count == c_CNT_LAST);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state       <= c_IDLE;
            r_count       <= '0;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= '0;
            r_rsp_timeout <= 1'b0;
            r_awaddr      <= '0;
            r_awvalid     <= 1'b0;
            r_wdata       <= '0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_araddr      <= '0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (r_cmd_ready && cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_count     <= '0;
                        if (cmd_write) begin
                            r_state   <= c_WRITE;
                            r_awaddr  <= cmd_addr;
                            r_wdata   <= cmd_wdata;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_bready  <= 1'b1;
                        end else begin
                            r_state   <= c_READ;
                            r_araddr  <= cmd_addr;
                            r_arvalid <= 1'b1;
                            r_rready  <= 1'b1;
                        end
                    end
                end
                c_WRITE: begin
                    r_count <= r_count + c_CNT_W'(1);
                    if (m_axi_awready) r_awvalid <= 1'b0;
                    if (m_axi_wready)  r_wvalid  <= 1'b0;
                    // A response arriving on the timeout edge still wins.
                    if (m_axi_bvalid || w_timeout) begin
                        r_state       <= c_RESP;
                        r_awvalid     <= 1'b0;
                        r_wvalid      <= 1'b0;
                        r_bready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_resp    <= m_axi_bvalid ? m_axi_bresp : 2'b10;
                        r_rsp_timeout <= !m_axi_bvalid;
                    end
                end
                c_READ: begin
                    r_count <= r_count + c_CNT_W'(1);
                    if (m_axi_arready) r_arvalid <= 1'b0;
                    if (m_axi_rvalid || w_timeout) begin
                        r_state       <= c_RESP;
                        r_arvalid     <= 1'b0;
                        r_rready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= m_axi_rvalid ? m_axi_rdata : 32'd0;
                        r_rsp_resp    <= m_axi_rvalid ? m_axi_rresp : 2'b10;
                        r_rsp_timeout <= !m_axi_rvalid;
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_timeout   = r_rsp_timeout;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_axil_cmd_master
// Brief   : Self-checking bench: directed table, random transactions, reset abort.
// Revision: 1.0
// ============================================================================
module tb_axil_cmd_master;

    localparam int c_AW = 32;
    localparam int c_TO = 16;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [c_AW-1:0] cmd_addr;
    logic [31:0]     cmd_wdata;
    logic            rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0]     rsp_rdata;
    logic [1:0]      rsp_resp;
    logic [c_AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic            m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [31:0]     m_axi_wdata, m_axi_rdata;
    logic [1:0]      m_axi_bresp, m_axi_rresp;
    logic            m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic            m_axi_rvalid, m_axi_rready;

    axil_cmd_master #(.ADDR_WIDTH(c_AW), .TIMEOUT(c_TO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          aw_dly;     // cycle index at which AW (or AR) ready rises
        int          w_dly;      // cycle index at which W ready rises
        int          extra;      // extra wait before B/R after the address/data beats
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          rsp_dly;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        bit          exp_to;
    } vec_t;

    int    n_vec = 0;
    int    n_err = 0;
    string cur_tag = "";

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got 0x%08h expected 0x%08h", cur_tag, name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %b expected %b", cur_tag, name, act, exp);
        end
    endtask

    // Cycle index (0 = first cycle after acceptance) on whose closing edge the slave completes.
    function automatic int done_cycle(input vec_t v);
        if (v.wr) return ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + v.extra;
        return v.aw_dly + 1 + v.extra;
    endfunction

    function automatic vec_t model(input vec_t v);
        vec_t r;
        r        = v;
        r.exp_to = (done_cycle(v) >= c_TO);
        r.exp_resp  = r.exp_to ? 2'b10 : v.resp;
        r.exp_rdata = (r.exp_to || v.wr) ? 32'd0 : v.rdata;
        return r;
    endfunction

    function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input int aw, input int w, input int ex, input logic [31:0] rdata,
                                input logic [1:0] resp, input int rd, input logic [31:0] erd,
                                input logic [1:0] eresp, input bit eto);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.aw_dly = aw; v.w_dly = w; v.extra = ex;
        v.rdata = rdata; v.resp = resp; v.rsp_dly = rd;
        v.exp_rdata = erd; v.exp_resp = eresp; v.exp_to = eto;
        return v;
    endfunction

    task automatic slave_idle();
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic run(input vec_t v);
        int dc, e, k;
        dc = done_cycle(v);
        e  = (dc >= c_TO) ? c_TO - 1 : dc;
        k  = 0;
        while (cmd_ready !== 1'b1 && k < 8) begin
            step();
            k++;
        end
        chk1("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        step();
        cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = $urandom_range(0, 1);
        for (int c = 0; c <= e; c++) begin
            chk1("cmd_ready_busy", cmd_ready, 1'b0);
            chk1("rsp_valid_busy", rsp_valid, 1'b0);
            if (v.wr) begin
                chk1("awvalid", m_axi_awvalid, c <= v.aw_dly);
                chk1("wvalid", m_axi_wvalid, c <= v.w_dly);
                chk1("bready", m_axi_bready, 1'b1);
                chk1("arvalid_w", m_axi_arvalid, 1'b0);
                if (c <= v.aw_dly) chk32("awaddr", m_axi_awaddr, v.addr);
                if (c <= v.w_dly)  chk32("wdata", m_axi_wdata, v.wdata);
                m_axi_awready = (c >= v.aw_dly);
                m_axi_wready  = (c >= v.w_dly);
                m_axi_bvalid  = (c >= dc);
                m_axi_bresp   = v.resp;
            end else begin
                chk1("arvalid", m_axi_arvalid, c <= v.aw_dly);
                chk1("rready", m_axi_rready, 1'b1);
                chk1("awvalid_r", m_axi_awvalid, 1'b0);
                chk1("wvalid_r", m_axi_wvalid, 1'b0);
                if (c <= v.aw_dly) chk32("araddr", m_axi_araddr, v.addr);
                m_axi_arready = (c >= v.aw_dly);
                m_axi_rvalid  = (c >= dc);
                m_axi_rdata   = v.rdata;
                m_axi_rresp   = v.resp;
            end
            step();
        end
        // Stray slave responses during RESP must not disturb the held response.
        slave_idle();
        m_axi_bvalid = 1; m_axi_bresp = ~v.resp;
        m_axi_rvalid = 1; m_axi_rresp = ~v.resp; m_axi_rdata = ~v.rdata;
        for (int i = 0; i <= v.rsp_dly; i++) begin
            chk1("rsp_valid", rsp_valid, 1'b1);
            chk32("rsp_rdata", rsp_rdata, v.exp_rdata);
            chk32("rsp_resp", 32'(rsp_resp), 32'(v.exp_resp));
            chk1("rsp_timeout", rsp_timeout, v.exp_to);
            chk1("cmd_ready_resp", cmd_ready, 1'b0);
            chk1("axi_quiet", m_axi_awvalid | m_axi_wvalid | m_axi_arvalid | m_axi_bready | m_axi_rready, 1'b0);
            rsp_ready = (i == v.rsp_dly);
            step();
        end
        rsp_ready = 0;
        slave_idle();
        chk1("rsp_valid_done", rsp_valid, 1'b0);
        chk1("cmd_ready_after", cmd_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        vec_t v;

        aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
        slave_idle();

        cur_tag = "reset";
        repeat (3) step();
        chk1("cmd_ready", cmd_ready, 1'b0);
        chk1("valids", m_axi_awvalid | m_axi_wvalid | m_axi_arvalid | rsp_valid, 1'b0);
        chk1("readies", m_axi_bready | m_axi_rready, 1'b0);
        chk32("rsp_rdata", rsp_rdata, 32'd0);
        chk32("rsp_resp", 32'(rsp_resp), 32'd0);
        chk1("rsp_timeout", rsp_timeout, 1'b0);
        aresetn = 1;
        step();
        chk1("cmd_ready_release", cmd_ready, 1'b1);

        //            wr  addr        wdata         aw  w  ex rdata         resp  rd erdata        eresp eto
        tbl[0] = mk(1, 32'h0,      32'hA5A5A5A5, 0,  0, 0, 32'h0,        2'b00, 0, 32'h0,        2'b00, 0);
        tbl[1] = mk(1, 32'h10,     32'hDEADBEEF, 0,  3, 0, 32'h0,        2'b00, 1, 32'h0,        2'b00, 0);
        tbl[2] = mk(0, 32'h4,      32'h0,        0,  0, 4, 32'h12345678, 2'b00, 4, 32'h12345678, 2'b00, 0);
        tbl[3] = mk(0, 32'h8,      32'h0,        1,  0, 0, 32'hCAFEF00D, 2'b10, 0, 32'hCAFEF00D, 2'b10, 0);
        tbl[4] = mk(0, 32'hC,      32'h0,        99, 0, 0, 32'h11111111, 2'b00, 2, 32'h0,        2'b10, 1);
        tbl[5] = mk(1, 32'h20,     32'h01234567, 2,  1, 1, 32'h0,        2'b11, 0, 32'h0,        2'b11, 0);
        tbl[6] = mk(1, 32'h24,     32'h89ABCDEF, 2,  50, 0, 32'h0,       2'b00, 1, 32'h0,        2'b10, 1);
        tbl[7] = mk(0, 32'h28,     32'h0,        3,  0, 11, 32'h5A5A5A5A, 2'b01, 0, 32'h5A5A5A5A, 2'b01, 0);
        tbl[8] = mk(1, 32'h2C,     32'h76543210, 16, 0, 0, 32'h0,        2'b00, 0, 32'h0,        2'b10, 1);
        tbl[9] = mk(1, 32'hFFFFFFFC, 32'hFFFFFFFF, 5, 15, 0, 32'h0,      2'b01, 0, 32'h0,        2'b01, 0);

        for (int i = 0; i < 10; i++) begin
            cur_tag = $sformatf("dir%0d", i);
            run(tbl[i]);
        end

        for (int i = 0; i < 40; i++) begin
            cur_tag = $sformatf("rnd%0d", i);
            v.wr      = $urandom_range(0, 1);
            v.addr    = $urandom & 32'hFFFFFFFC;
            v.wdata   = $urandom;
            v.aw_dly  = $urandom_range(0, 6);
            v.w_dly   = $urandom_range(0, 6);
            v.extra   = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 30) : $urandom_range(0, 5);
            v.rdata   = $urandom;
            v.resp    = 2'($urandom_range(0, 3));
            v.rsp_dly = $urandom_range(0, 3);
            run(model(v));
        end

        cur_tag = "reset_mid";
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'h55AA55AA;
        step();
        cmd_valid = 0;
        chk1("awvalid_before", m_axi_awvalid, 1'b1);
        aresetn = 0;
        step();
        chk1("valids_in_reset", m_axi_awvalid | m_axi_wvalid | m_axi_arvalid | rsp_valid, 1'b0);
        chk1("bready_in_reset", m_axi_bready, 1'b0);
        chk1("cmd_ready_in_reset", cmd_ready, 1'b0);
        aresetn = 1;
        m_axi_bvalid = 1; m_axi_rvalid = 1;
        step();
        chk1("cmd_ready_release", cmd_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk1("no_rsp", rsp_valid, 1'b0);
            chk1("no_valids", m_axi_awvalid | m_axi_wvalid | m_axi_arvalid, 1'b0);
            step();
        end
        slave_idle();

        cur_tag = "post_reset";
        run(mk(0, 32'h44, 32'h0, 0, 0, 0, 32'h0BADF00D, 2'b00, 0, 32'h0BADF00D, 2'b00, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
